// File: rtl/bsg_link_pkg.sv
// bsg_link_pkg: shared link widths, credit constants and upstream FSM state type
package bsg_link_pkg;

    localparam int CORE_W      = 32;
    localparam int IO_W        = 8;
    localparam int CREDIT_MAX  = 64;
    localparam int TOKEN_BATCH = 8;
    localparam int CREDIT_W    = $clog2(CREDIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3
    } up_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry valid/ready buffer; enq_ready reflects pre-dequeue occupancy
module bsg_two_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enq_valid,
    input  logic [W-1:0] enq_data,
    output logic         enq_ready,
    output logic         deq_valid,
    output logic [W-1:0] deq_data,
    input  logic         deq_yumi
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign enq_ready = cnt != 2'd2;
    assign deq_valid = cnt != 2'd0;
    assign push      = enq_valid & enq_ready;
    assign pop       = deq_yumi & deq_valid;
    assign deq_data  = mem[rptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop) rptr <= ~rptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    // storage needs no reset: it is only read while deq_valid is high
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= enq_data;
    end

endmodule

// File: rtl/bsg_upstream_ch.sv
// bsg_upstream_ch: credit-flow upstream channel serializing core words into io bytes
module bsg_upstream_ch #(
    parameter int CORE_W      = bsg_link_pkg::CORE_W,
    parameter int IO_W        = bsg_link_pkg::IO_W,
    parameter int CREDIT_MAX  = bsg_link_pkg::CREDIT_MAX,
    parameter int TOKEN_BATCH = bsg_link_pkg::TOKEN_BATCH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              core_valid_in,
    input  logic [CORE_W-1:0]                 core_data_in,
    output logic                              core_ready_out,
    output logic                              io_valid_out,
    output logic [IO_W-1:0]                   io_data_out,
    input  logic                              io_token_in,
    output logic [$clog2(CREDIT_MAX+1)-1:0]   credit_cnt,
    output logic                              credit_err
);

    import bsg_link_pkg::*;

    localparam int CW = $clog2(CREDIT_MAX + 1);

    up_state_e         state;
    up_state_e         state_nxt;
    logic              fifo_valid;
    logic [CORE_W-1:0] fifo_data;
    logic              fifo_yumi;
    logic              emit;
    logic              consume;
    logic [1:0]        byte_sel;
    logic [IO_W-1:0]   byte_mux;
    logic              has_credit;
    logic              token_r;
    logic              token_toggle;
    logic [CW:0]       credit_sum;

    bsg_two_fifo #(.W(CORE_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (core_valid_in),
        .enq_data  (core_data_in),
        .enq_ready (core_ready_out),
        .deq_valid (fifo_valid),
        .deq_data  (fifo_data),
        .deq_yumi  (fifo_yumi)
    );

    assign has_credit   = credit_cnt != '0;
    assign token_toggle = io_token_in ^ token_r;
    assign byte_mux     = fifo_data[IO_W*int'(byte_sel) +: IO_W];
    // a returned batch and a consumed credit on the same edge net together
    assign credit_sum   = {1'b0, credit_cnt}
                        + (token_toggle ? (CW+1)'(TOKEN_BATCH) : '0)
                        - (CW+1)'(consume);

    // next-state and per-edge byte emission; each half-word start costs one credit
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        consume   = 1'b0;
        fifo_yumi = 1'b0;
        byte_sel  = 2'd0;
        case (state)
            IDLE: begin
                if (fifo_valid && has_credit) begin
                    state_nxt = B0;
                    emit      = 1'b1;
                    consume   = 1'b1;
                end
            end
            B0: begin
                state_nxt = B1;
                emit      = 1'b1;
                byte_sel  = 2'd1;
            end
            B1: begin
                if (has_credit) begin
                    state_nxt = B2;
                    emit      = 1'b1;
                    consume   = 1'b1;
                    byte_sel  = 2'd2;
                end
            end
            B2: begin
                state_nxt = B3;
                emit      = 1'b1;
                fifo_yumi = 1'b1;
                byte_sel  = 2'd3;
            end
            B3: begin
                state_nxt = (fifo_valid && has_credit) ? B0 : IDLE;
                emit      = fifo_valid && has_credit;
                consume   = fifo_valid && has_credit;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end

    // registered io byte lane; data holds its last value while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_valid_out <= 1'b0;
            io_data_out  <= '0;
        end else begin
            io_valid_out <= emit;
            if (emit) io_data_out <= byte_mux;
        end
    end

    // credit counter with token-toggle returns, saturation and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= CW'(CREDIT_MAX);
            credit_err <= 1'b0;
            token_r    <= 1'b0;
        end else begin
            token_r <= io_token_in;
            if (credit_sum > (CW+1)'(CREDIT_MAX)) begin
                credit_cnt <= CW'(CREDIT_MAX);
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_sum[CW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bsg_upstream_ch.sv
// tb_bsg_upstream_ch: vector table, corner sequences and random traffic against a credit/stream model
module tb_bsg_upstream_ch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_valid_in = 1'b0;
    logic [31:0] core_data_in = 32'h0;
    logic        core_ready_out;
    logic        io_valid_out;
    logic [7:0]  io_data_out;
    logic        io_token_in = 1'b0;
    logic [6:0]  credit_cnt;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int          cr = 64;
    logic        err_m = 1'b0;
    int          bidx = 0;
    logic        prev_tok = 1'b0;
    logic [7:0]  last_b = 8'h0;
    int          nbytes = 0;
    logic        tok = 1'b0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        t;
        logic        ev;
        logic [7:0]  ed;
        int          ec;
        logic        er;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    bsg_upstream_ch dut (
        .clk            (clk),
        .rst            (rst),
        .core_valid_in  (core_valid_in),
        .core_data_in   (core_data_in),
        .core_ready_out (core_ready_out),
        .io_valid_out   (io_valid_out),
        .io_data_out    (io_data_out),
        .io_token_in    (io_token_in),
        .credit_cnt     (credit_cnt),
        .credit_err     (credit_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cr       = 64;
        err_m    = 1'b0;
        bidx     = 0;
        prev_tok = 1'b0;
        last_b   = 8'h0;
    endtask

    // one clock: drive inputs, advance the edge, then score the outputs against the model
    task automatic cycle(input logic v, input logic [31:0] d, input logic t, output logic acc);
        logic       tog;
        logic       must;
        logic       cons;
        int         sum;
        logic [7:0] eb;
        core_valid_in = v;
        core_data_in  = d;
        io_token_in   = t;
        acc  = v && core_ready_out;
        tog  = t != prev_tok;
        must = (bidx % 2 == 1) || (q.size() > 0 && cr > 0);
        @(posedge clk);
        #1;
        chk("io_valid", 32'(io_valid_out), 32'(must));
        cons = 1'b0;
        if (io_valid_out) begin
            nbytes++;
            if (q.size() == 0) begin
                chk("stream_word_pending", 32'(q.size()), 32'd1);
            end else begin
                eb = 8'(q[0] >> (8 * bidx));
                chk("io_data", 32'(io_data_out), 32'(eb));
                last_b = eb;
                if (bidx == 3) q.delete(0);
            end
            cons = (bidx == 0 || bidx == 2);
            bidx = (bidx + 1) % 4;
        end else begin
            chk("io_data_hold", 32'(io_data_out), 32'(last_b));
        end
        if (acc) q.push_back(d);
        sum = cr + (tog ? 8 : 0) - int'(cons);
        if (sum > 64) begin
            cr    = 64;
            err_m = 1'b1;
        end else begin
            cr = sum;
        end
        prev_tok = t;
        chk("credit_cnt", 32'(credit_cnt), 32'(cr));
        chk("credit_err", 32'(credit_err), 32'(err_m));
        chk("core_ready", 32'(core_ready_out), 32'(q.size() < 2));
    endtask

    task automatic do_reset();
        core_valid_in = 1'b0;
        tok           = 1'b0;
        io_token_in   = 1'b0;
        rst           = 1'b0;
        #1;
        chk("rst_valid", 32'(io_valid_out), 32'd0);
        chk("rst_data", 32'(io_data_out), 32'd0);
        chk("rst_credit", 32'(credit_cnt), 32'd64);
        chk("rst_err", 32'(credit_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        chk("rst_ready", 32'(core_ready_out), 32'd1);
    endtask

    task automatic drain();
        int   g = 0;
        logic a;
        while (q.size() > 0 && g < 1000) begin
            cycle(1'b0, 32'h0, tok, a);
            g++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic send_words(input int n);
        int   got = 0;
        int   g = 0;
        logic a;
        while (got < n && g < 2000) begin
            cycle(1'b1, $urandom, tok, a);
            got += int'(a);
            g++;
        end
        chk("send_accepted", 32'(got), 32'(n));
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic a;
        int   b0;
        tbl[0] = '{1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 8'h00, 64, 1'b1};
        tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hAA, 63, 1'b1};
        tbl[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 63, 1'b1};
        tbl[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 62, 1'b1};
        tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'hDD, 62, 1'b1};
        tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'hDD, 62, 1'b1};
        #2;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].t, a);
            chk("vec_valid", 32'(io_valid_out), 32'(tbl[i].ev));
            chk("vec_data", 32'(io_data_out), 32'(tbl[i].ed));
            chk("vec_credit", 32'(credit_cnt), 32'(tbl[i].ec));
            chk("vec_ready", 32'(core_ready_out), 32'(tbl[i].er));
        end

        do_reset();
        b0 = nbytes;
        for (int i = 0; i < 200; i++) cycle(1'b1, $urandom, 1'b0, a);
        chk("flood_bytes", 32'(nbytes - b0), 32'd128);
        chk("flood_credit", 32'(credit_cnt), 32'd0);
        chk("flood_valid", 32'(io_valid_out), 32'd0);
        chk("flood_ready", 32'(core_ready_out), 32'd0);

        do_reset();
        send_words(2);
        chk("pre_sat_credit", 32'(credit_cnt), 32'd60);
        tok = 1'b1;
        cycle(1'b0, 32'h0, tok, a);
        chk("sat_credit", 32'(credit_cnt), 32'd64);
        chk("sat_err", 32'(credit_err), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, tok, a);
        chk("err_sticky", 32'(credit_err), 32'd1);

        cycle(1'b1, $urandom, tok, a);
        cycle(1'b0, 32'h0, tok, a);
        tok = ~tok;
        cycle(1'b0, 32'h0, tok, a);
        chk("midword_sat_credit", 32'(credit_cnt), 32'd64);
        drain();
        chk("odd_credit", 32'(credit_cnt), 32'd63);
        send_words(31);
        chk("one_credit", 32'(credit_cnt), 32'd1);

        cycle(1'b1, 32'h44332211, tok, a);
        cycle(1'b0, 32'h0, tok, a);
        chk("stall_b0", 32'(io_data_out), 32'h11);
        chk("stall_b0_credit", 32'(credit_cnt), 32'd0);
        cycle(1'b0, 32'h0, tok, a);
        chk("stall_b1", 32'(io_data_out), 32'h22);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, tok, a);
            chk("stall_idle", 32'(io_valid_out), 32'd0);
        end
        tok = ~tok;
        cycle(1'b0, 32'h0, tok, a);
        chk("stall_return", 32'(credit_cnt), 32'd8);
        cycle(1'b0, 32'h0, tok, a);
        chk("resume_b2", 32'(io_data_out), 32'h33);
        cycle(1'b0, 32'h0, tok, a);
        chk("resume_b3", 32'(io_data_out), 32'h44);
        chk("resume_credit", 32'(credit_cnt), 32'd7);

        do_reset();
        send_words(27);
        chk("pre_net_credit", 32'(credit_cnt), 32'd10);
        cycle(1'b1, $urandom, tok, a);
        tok = 1'b1;
        cycle(1'b0, 32'h0, tok, a);
        chk("net_valid", 32'(io_valid_out), 32'd1);
        chk("net_credit", 32'(credit_cnt), 32'd17);
        drain();

        do_reset();
        cycle(1'b1, 32'h11223344, 1'b0, a);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, a);
        chk("pre_abort_b2", 32'(io_data_out), 32'h22);
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(io_valid_out), 32'd0);
        chk("abort_credit", 32'(credit_cnt), 32'd64);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 32'h0D0C0B0A, 1'b0, a);
        chk("post_abort_quiet", 32'(io_valid_out), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, a);
        chk("post_abort_b0", 32'(io_data_out), 32'h0A);
        drain();

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) tok = ~tok;
            cycle($urandom_range(0, 3) != 0, $urandom, tok, a);
        end
        for (int g = 0; g < 2000 && q.size() > 0; g++) begin
            if (g % 10 == 0) tok = ~tok;
            cycle(1'b0, 32'h0, tok, a);
        end
        chk("rand_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_upstream_ch.md
BSG_UPSTREAM_CH -- requirements
Module: bsg_upstream_ch

Interface
REQ-001 SHALL have parameter CORE_W, default 32, core word width.
REQ-002 SHALL have parameter IO_W, default 8, io byte width.
REQ-003 SHALL have parameter CREDIT_MAX, default 64, number of receiver half-word entries.
REQ-004 SHALL have parameter TOKEN_BATCH, default 8, credits returned per token toggle.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port core_valid_in, input, 1, core word offered.
REQ-008 SHALL have port core_data_in, input, 32, core word.
REQ-009 SHALL have port core_ready_out, output, 1, block can accept a word.
REQ-010 SHALL have port io_valid_out, output, 1, io byte valid this cycle.
REQ-011 SHALL have port io_data_out, output, 8, io byte.
REQ-012 SHALL have port io_token_in, input, 1, credit token level from receiver; each toggle = TOKEN_BATCH credits.
REQ-013 SHALL have port credit_cnt, output, 7, current credits (debug).
REQ-014 SHALL have port credit_err, output, 1, sticky credit-overflow flag.

Function
REQ-015 SHALL accept a word when core_valid_in & core_ready_out at a rising clk edge; core_ready_out = input FIFO (2 entries) not full.
REQ-016 SHALL serialize each word as 4 bytes, order data[7:0], [15:8], [23:16], [31:24]; bytes 0-1 form half-word 0, bytes 2-3 form half-word 1.
REQ-017 SHALL register io_valid_out/io_data_out; first byte of a word accepted at edge t appears at earliest after edge t+1 (FIFO-empty, credits available).
REQ-018 SHALL use FSM states IDLE, B0, B1, B2, B3; IDLE->B0 when FIFO non-empty and credit_cnt>0; B0->B1, B2->B3 unconditional; B1->B2 when credit_cnt>0, else hold in B1 with io_valid_out=0 until credit; B3->B0 if next word present and credit>0, else IDLE.
REQ-019 SHALL consume one credit at emission of byte 0 and byte 2 (start of each half-word); never emit byte 0 or 2 with credit_cnt=0.
REQ-020 SHALL pop the FIFO at emission of byte 3; back-to-back words stream with no idle cycle when credits suffice.
REQ-021 SHALL detect token toggles by comparing io_token_in with a registered copy; either edge adds TOKEN_BATCH.
REQ-022 SHALL apply simultaneous token return and consumption as net +TOKEN_BATCH-1 in the same edge.
REQ-023 SHALL saturate credit_cnt at CREDIT_MAX and set credit_err (sticky until reset) if a return would exceed CREDIT_MAX.
REQ-024 SHALL hold io_data_out at last value when io_valid_out=0.
REQ-025 SHALL allow simultaneous FIFO push and pop when full (ready reflects pre-pop occupancy, i.e. deasserted when full).

Reset
REQ-026 SHALL on rst=0 asynchronously set: state IDLE, FIFO empty, core_ready_out 1 after release, io_valid_out 0, io_data_out 0, credit_cnt CREDIT_MAX, credit_err 0, token register 0.
REQ-027 SHALL discard any partially sent word on reset mid-operation; no byte emitted in the first cycle after release.

Structure
REQ-028 SHALL place CREDIT_MAX, TOKEN_BATCH, IO_W, CORE_W and the FSM state typedef in shared package bsg_link_pkg.
REQ-029 SHALL instantiate one sub-module bsg_two_fifo (2-entry, valid/ready, CORE_W wide) for input buffering.

Verification
REQ-030 Single word 0xDDCCBBAA, full credits -> bytes AA,BB,CC,DD on 4 consecutive cycles, credit_cnt 64->62.
REQ-031 Push 40 words, no tokens -> exactly 32 words (128 bytes) sent, credit_cnt 0, io_valid_out low, core_ready_out low once FIFO full.
REQ-032 From credit_cnt 1, word 0x44332211 -> bytes 11,22 sent, stall in B1; toggle io_token_in -> 33,44 follow, credit_cnt ends 7.
REQ-033 Token toggle on same edge as byte-0 emission at credit 10 -> credit_cnt 17.
REQ-034 At credit_cnt 60 toggle token -> credit_cnt 64, credit_err 1 and stays 1.
REQ-035 Assert rst during byte B2 -> io_valid_out 0 immediately, credit_cnt 64, next word starts at byte 0.
